// File: rtl/fp_mul_arbiter_if.sv
// Requester-side bus of fp_mul_arbiter.
//   req_valid / req_ready : per-requester handshake, pair i accepted when both high
//   req_a / req_b         : packed operands, requester i in bits [i*W +: W]
//   rsp_valid             : one-hot, single-cycle result strobe
//   rsp_d                 : result, meaningful while any rsp_valid bit is high
// master = requesters (field-arithmetic sequencers), slave = the arbiter.
interface fp_mul_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = 255
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [W-1:0]         rsp_d;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_d
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_d
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin scheduler sharing one pipelined fp_mul between NUM_REQ requesters.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   en       : grant enable; low stops new grants, in-flight ops still drain
//   bus      : requester handshake/operand/response bus (slave side)
//   mul_a/b  : operands to fp_mul, zero when nothing is granted
//   mul_d    : fp_mul result, valid LATENCY_MUL cycles after the operands
//   inflight : ops accepted whose response has not been strobed yet
//   idle     : inflight == 0
// fp_mul carries no valid or tag, so a shadow pipeline of {valid, id} of the
// same depth tells which requester owns each result as it leaves the multiplier.
module fp_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned LATENCY_MUL = 9,
  parameter int unsigned W           = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  fp_mul_arbiter_if.slave                    bus,
  output logic [W-1:0]                       mul_a,
  output logic [W-1:0]                       mul_b,
  input  logic [W-1:0]                       mul_d,
  output logic [$clog2(LATENCY_MUL+2)-1:0]   inflight,
  output logic                               idle
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(LATENCY_MUL + 2);

  // Round-robin pointer: search for a valid request starts here.
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_ptr_d;

  // Grant decode.
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;

  // Tag pipeline; the last stage lines up with mul_d.
  logic            tag_vld_q [LATENCY_MUL];
  logic [ID_W-1:0] tag_id_q  [LATENCY_MUL];

  // Registered response.
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [NUM_REQ-1:0] rsp_valid_d;
  logic [W-1:0]       rsp_d_q;
  logic               rsp_any;

  logic [CNT_W-1:0] inflight_q;

  // ---------------------------------------------------------------------------
  // Arbitration: first valid request at or after rr_ptr, wrapping modulo
  // NUM_REQ. Gating with rst keeps req_ready low while reset is held, so no
  // handshake can complete against a pipeline that is being cleared.
  // ---------------------------------------------------------------------------
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] cand;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    cand    = '0;
    if (en && !rst) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx  = (int'(rr_ptr_q) + k) % NUM_REQ;
        cand = ID_W'(idx);
        if (!gnt_any && bus.req_valid[cand]) begin
          gnt_any   = 1'b1;
          gnt[cand] = 1'b1;
          gnt_id    = cand;
        end
      end
    end
  end

  assign bus.req_ready = gnt;

  // Pointer moves past the winner so it becomes lowest priority next time.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = ID_W'((int'(gnt_id) + 1) % int'(NUM_REQ));
    end
  end

  // Operand mux: granted requester's pair, zero otherwise.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (gnt_any) begin
      mul_a = bus.req_a[gnt_id*W +: W];
      mul_b = bus.req_b[gnt_id*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: loads every edge (a bubble when nothing was granted) and
  // never stalls, exactly like the multiplier it shadows.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < LATENCY_MUL; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_id_q[s]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= gnt_any;
      tag_id_q[0]  <= gnt_id;
      for (int unsigned s = 1; s < LATENCY_MUL; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response: steer the tail result to its owner. mul_d is only sampled when
  // the tail tag is valid, so anything the multiplier emits for bubbles or for
  // ops discarded by reset never reaches a requester.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = tag_vld_q[LATENCY_MUL-1] && (tag_id_q[LATENCY_MUL-1] == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_d_q     <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (tag_vld_q[LATENCY_MUL-1]) begin
        rsp_d_q <= mul_d;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_d     = rsp_d_q;
  assign rsp_any       = |rsp_valid_q;

  // ---------------------------------------------------------------------------
  // Occupancy: +1 per accept, -1 per response strobe; both together cancel.
  // Bounded by LATENCY_MUL+1 (full pipe plus the response register).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
    end else if (gnt_any && !rsp_any) begin
      inflight_q <= inflight_q + 1'b1;
    end else if (!gnt_any && rsp_any) begin
      inflight_q <= inflight_q - 1'b1;
    end
  end

  assign inflight = inflight_q;
  assign idle     = (inflight_q == '0);

endmodule
